// File: rtl/spk_write_packer.sv
// Packs a stream of 2-bit spikes, eight per 16-bit word, and writes each word to the
// spike SRAM at consecutive addresses starting from a configured base.
module spk_write_packer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int SPK_W  = 2,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [SPK_W-1:0]  spk_in,
  input  logic              spk_in_valid,
  output logic              spk_in_ready,
  output logic [DATA_W-1:0] spk_write_sram,
  output logic [ADDR_W-1:0] spk_write_sram_addr,
  output logic              spk_write_sram_we,
  output logic              busy,
  output logic              done
);

  localparam int FIELDS = DATA_W / SPK_W;
  localparam int IDX_W  = $clog2(FIELDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [IDX_W-1:0]  field_idx_r;
  logic [DATA_W-1:0] pack_r;
  logic [DATA_W-1:0] pack_ins_s;
  logic              accept_s;
  logic              last_s;

  // Next-state logic and the pack word with the incoming spike merged in.
  always_comb begin
    state_nxt_s = state_r;
    pack_ins_s  = pack_r;
    accept_s    = spk_in_valid && spk_in_ready;
    last_s      = (field_idx_r == IDX_W'(FIELDS - 1)) || (remaining_r == CNT_W'(1));
    for (int k = 0; k < FIELDS; k++) begin
      if (field_idx_r == IDX_W'(k)) begin
        pack_ins_s[k*SPK_W +: SPK_W] = spk_in;
      end else begin
        pack_ins_s[k*SPK_W +: SPK_W] = pack_r[k*SPK_W +: SPK_W];
      end
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (cfg_count == CNT_W'(0)) ? ST_DONE : ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (accept_s && last_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        state_nxt_s = (remaining_r == CNT_W'(0)) ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, job bookkeeping and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      addr_r              <= '0;
      remaining_r         <= '0;
      field_idx_r         <= '0;
      pack_r              <= '0;
      spk_in_ready        <= 1'b0;
      spk_write_sram      <= '0;
      spk_write_sram_addr <= '0;
      spk_write_sram_we   <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      spk_in_ready      <= (state_nxt_s == ST_FILL);
      spk_write_sram_we <= (state_nxt_s == ST_WRITE);
      busy              <= (state_nxt_s != ST_IDLE);
      done              <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r      <= cfg_base_addr;
            remaining_r <= cfg_count;
            field_idx_r <= '0;
            pack_r      <= '0;
          end
        end
        ST_FILL: begin
          if (accept_s) begin
            pack_r      <= pack_ins_s;
            field_idx_r <= field_idx_r + IDX_W'(1);
            remaining_r <= remaining_r - CNT_W'(1);
            // Write data/address are captured only for a closing spike, so they hold otherwise.
            if (last_s) begin
              spk_write_sram      <= pack_ins_s;
              spk_write_sram_addr <= addr_r;
            end
          end
        end
        ST_WRITE: begin
          addr_r      <= addr_r + ADDR_W'(1);
          pack_r      <= '0;
          field_idx_r <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
